// File: rtl/bc_turn_controller.sv
// Bulls & Cows turn sequencer: secret capture, alternating guesses, serial scoring.
// Ports: clock/reset(sync, active-low), confirm_pulse, sw -> state, scores, attempts, winner.
module bc_turn_controller #(
  parameter int DIGITS    = 4,
  parameter int DW        = 4,
  parameter int MAX_DIGIT = 9
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 confirm_pulse,
  input  logic [DIGITS*DW-1:0] sw,
  output logic [3:0]           state_o,
  output logic                 player_o,
  output logic [2:0]           bulls,
  output logic [2:0]           cows,
  output logic                 result_valid,
  output logic                 input_error,
  output logic [3:0]           attempts_j1,
  output logic [3:0]           attempts_j2,
  output logic [1:0]           winner
);

  typedef enum logic [3:0] {
    SECRET_J1 = 4'd0,
    SECRET_J2 = 4'd1,
    GUESS_J1  = 4'd2,
    SCORE_J1  = 4'd3,
    SHOW_J1   = 4'd4,
    GUESS_J2  = 4'd5,
    SCORE_J2  = 4'd6,
    SHOW_J2   = 4'd7,
    WIN       = 4'd8
  } state_t;

  localparam logic [DW-1:0] MAXD = DW'(MAX_DIGIT);

  state_t state, state_nx;

  logic [DIGITS*DW-1:0] secret_j1, secret_j2, guess;
  logic [2:0]           cnt;
  logic [2:0]           bull_acc, cow_acc;

  logic code_ok;
  logic entry;
  logic scoring;
  logic accept, reject;
  logic [1:0]           k;
  logic [DW-1:0]        g_k;
  logic [DIGITS*DW-1:0] cur_secret;
  logic hit_bull, hit_any;

  // Legal code: all digits in range and pairwise distinct.
  always_comb begin
    code_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (sw[DW*i +: DW] > MAXD) code_ok = 1'b0;
      for (int j = i + 1; j < DIGITS; j++)
        if (sw[DW*i +: DW] == sw[DW*j +: DW]) code_ok = 1'b0;
    end
  end

  assign entry   = (state == SECRET_J1) || (state == SECRET_J2) ||
                   (state == GUESS_J1)  || (state == GUESS_J2);
  assign scoring = (state == SCORE_J1) || (state == SCORE_J2);
  assign accept  = entry && confirm_pulse && code_ok;
  assign reject  = entry && confirm_pulse && !code_ok;

  // J1 guesses are scored against J2's secret and vice versa.
  assign cur_secret = (state == SCORE_J2) ? secret_j1 : secret_j2;
  assign k          = cnt[1:0];
  assign g_k        = guess[DW*k +: DW];

  always_comb begin
    hit_bull = (g_k == cur_secret[DW*k +: DW]);
    hit_any  = 1'b0;
    for (int j = 0; j < DIGITS; j++)
      if (g_k == cur_secret[DW*j +: DW]) hit_any = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset) state <= SECRET_J1;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      SECRET_J1: if (accept) state_nx = SECRET_J2;
      SECRET_J2: if (accept) state_nx = GUESS_J1;
      GUESS_J1:  if (accept) state_nx = SCORE_J1;
      GUESS_J2:  if (accept) state_nx = SCORE_J2;
      SCORE_J1:
        if (cnt == 3'd4)
          state_nx = (bull_acc == 3'd4) ? WIN : SHOW_J1;
      SCORE_J2:
        if (cnt == 3'd4)
          state_nx = (bull_acc == 3'd4) ? WIN : SHOW_J2;
      SHOW_J1:   if (confirm_pulse) state_nx = GUESS_J2;
      SHOW_J2:   if (confirm_pulse) state_nx = GUESS_J1;
      WIN:       state_nx = WIN;
      default:   state_nx = SECRET_J1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      secret_j1    <= '0;
      secret_j2    <= '0;
      guess        <= '0;
      cnt          <= '0;
      bull_acc     <= '0;
      cow_acc      <= '0;
      bulls        <= '0;
      cows         <= '0;
      result_valid <= 1'b0;
      input_error  <= 1'b0;
      attempts_j1  <= '0;
      attempts_j2  <= '0;
      winner       <= '0;
    end else begin
      result_valid <= 1'b0;
      input_error  <= reject;
      if (accept) begin
        if (state == SECRET_J1) secret_j1 <= sw;
        if (state == SECRET_J2) secret_j2 <= sw;
        if (state == GUESS_J1 || state == GUESS_J2) begin
          guess    <= sw;
          cnt      <= '0;
          bull_acc <= '0;
          cow_acc  <= '0;
        end
      end
      if (scoring) begin
        if (cnt != 3'd4) begin
          cnt <= cnt + 3'd1;
          if (hit_bull)     bull_acc <= bull_acc + 3'd1;
          else if (hit_any) cow_acc  <= cow_acc + 3'd1;
        end else begin
          bulls        <= bull_acc;
          cows         <= cow_acc;
          result_valid <= 1'b1;
          if (state == SCORE_J1) begin
            if (attempts_j1 != 4'hF) attempts_j1 <= attempts_j1 + 4'd1;
            if (bull_acc == 3'd4)    winner <= 2'd1;
          end else begin
            if (attempts_j2 != 4'hF) attempts_j2 <= attempts_j2 + 4'd1;
            if (bull_acc == 3'd4)    winner <= 2'd2;
          end
        end
      end
    end
  end

  assign state_o  = state;
  assign player_o = (state == SECRET_J2) || (state == GUESS_J2) ||
                    (state == SCORE_J2)  || (state == SHOW_J2);

endmodule
